// File: rtl/memory_stage.sv
// RV32I memory stage: drives the data-memory handshake for loads and stores
// and registers results into the writeback (E) pipeline register.
module memory_stage #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] TIMEOUT    = 4'd15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [DATA_WIDTH-1:0] ALUResultD,
    input  logic [DATA_WIDTH-1:0] MemWriteDataD,
    input  logic [4:0]            RdD,
    input  logic [2:0]            Funct3D,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  StallM,
    output logic [4:0]            RdDH,
    output logic                  RegWriteDH,
    output logic [DATA_WIDTH-1:0] ForwardALUResultDH,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic [4:0]            RdE,
    output logic [DATA_WIDTH-1:0] ALUResultE,
    output logic [DATA_WIDTH-1:0] ReadDataE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic                  FaultE,
    output logic [1:0]            FaultCauseE
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t     state;
    logic [3:0] cnt;

    logic        access;
    logic        load;
    logic        illegal;
    logic        misal;
    logic        fault;
    logic [1:0]  cause;
    logic        timeout;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rext;

    assign access  = MemWriteD | (ResultSrcD == 2'b01);
    assign load    = access & ~MemWriteD;
    assign illegal = MemWriteD ? (Funct3D > 3'b010)
                               : (Funct3D == 3'b011 || Funct3D[2:1] == 2'b11);
    assign misal   = (Funct3D[1:0] == 2'b01 && ALUResultD[0])
                   | (Funct3D[1:0] == 2'b10 && ALUResultD[1:0] != 2'b00);
    assign fault   = access & (illegal | misal);
    assign cause   = illegal ? 2'b10 : 2'b01;

    // cnt counts completed wait cycles; the stall then lasts TIMEOUT+1 cycles
    assign timeout = (state == S_WAIT) & ~mem_ready
                   & (cnt == TIMEOUT - 4'd1);

    assign mem_req = rst_n & ((state == S_WAIT) ? ~timeout
                                                : access & ~fault);
    assign StallM  = rst_n & ((state == S_WAIT) ? ~mem_ready
                                                : access & ~fault & ~mem_ready);
    assign mem_we   = mem_req & MemWriteD;
    assign mem_addr = {ALUResultD[31:2], 2'b00};

    assign RdDH               = RdD;
    assign RegWriteDH         = RegWriteD;
    assign ForwardALUResultDH = ALUResultD;

    always_comb begin
        mem_wdata = MemWriteDataD;
        mem_be    = 4'b1111;
        unique case (1'b1)
            MemWriteD && Funct3D[1:0] == 2'b00: begin
                mem_wdata = {4{MemWriteDataD[7:0]}};
                mem_be    = 4'b0001 << ALUResultD[1:0];
            end
            MemWriteD && Funct3D[1:0] == 2'b01: begin
                mem_wdata = {2{MemWriteDataD[15:0]}};
                mem_be    = ALUResultD[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ALUResultD[1:0])
            2'b01:   rbyte = mem_rdata[15:8];
            2'b10:   rbyte = mem_rdata[23:16];
            2'b11:   rbyte = mem_rdata[31:24];
            default: rbyte = mem_rdata[7:0];
        endcase
        rhalf = ALUResultD[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (Funct3D)
            3'b000:  rext = {{24{rbyte[7]}}, rbyte};
            3'b100:  rext = {24'b0, rbyte};
            3'b001:  rext = {{16{rhalf[15]}}, rhalf};
            3'b101:  rext = {16'b0, rhalf};
            default: rext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            RdE         <= 5'd0;
            ALUResultE  <= '0;
            ReadDataE   <= '0;
            PCPlus4E    <= '0;
            FaultE      <= 1'b0;
            FaultCauseE <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req && !mem_ready) begin
                        state <= S_WAIT;
                        cnt   <= 4'd0;
                    end
                end
                default: begin
                    if (mem_ready || timeout) state <= S_IDLE;
                    else                      cnt   <= cnt + 4'd1;
                end
            endcase

            RdE        <= RdD;
            ALUResultE <= ALUResultD;
            PCPlus4E   <= PCPlus4D;
            if (timeout) begin
                RegWriteE   <= 1'b0;
                ResultSrcE  <= ResultSrcD;
                ReadDataE   <= '0;
                FaultE      <= 1'b1;
                FaultCauseE <= 2'b11;
            end else if (StallM) begin
                RegWriteE   <= 1'b0;
                ResultSrcE  <= 2'b00;
                ReadDataE   <= '0;
                FaultE      <= 1'b0;
                FaultCauseE <= 2'b00;
            end else if (fault) begin
                RegWriteE   <= 1'b0;
                ResultSrcE  <= ResultSrcD;
                ReadDataE   <= '0;
                FaultE      <= 1'b1;
                FaultCauseE <= cause;
            end else begin
                RegWriteE   <= RegWriteD;
                ResultSrcE  <= ResultSrcD;
                ReadDataE   <= load ? rext : '0;
                FaultE      <= 1'b0;
                FaultCauseE <= 2'b00;
            end
        end
    end

endmodule
